// File: rtl/apb_cmd_master.sv
// apb_cmd_master
// APB4 master with a valid/ready command port and a valid/ready response port.
// Each accepted command becomes one APB transfer, and at most one transfer is
// in flight. The master captures PSLVERR. It can abort a transfer that waits
// too long, using the TIMEOUT count of wait-state ACCESS cycles (0 = never).
//
// Ports
//   pclk, rst_n          clock (rising edge) and async active-low reset
//   cmd_*                command: valid/ready, write, addr, wdata, strb
//   rsp_*                response: valid/ready, rdata, err, timeout
//   paddr..pstrb         APB request outputs (psel pre-decoded for one slave)
//   prdata/pready/pslverr APB slave returns
module apb_cmd_master #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   paddr,
    output logic                pwrite,
    output logic                psel,
    output logic                penable,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);
    localparam int STRB_W = DATA_W / 8;
    // Keep at least one bit so TIMEOUT=0 still elaborates.
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;

        case (state_q)
            S_IDLE: begin
                // Every output is a flop, so cmd_ready rises one edge after reset release.
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = S_SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    cnt_d       = '0;
                    paddr_d     = cmd_addr;
                    pwrite_d    = cmd_write;
                    pwdata_d    = cmd_wdata;
                    pstrb_d     = cmd_write ? cmd_strb : '0;
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                if (pready) begin
                    state_d       = S_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    // This is the TIMEOUT-th consecutive not-ready edge.
                    state_d       = S_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          cmd_strb = 1'b0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] paddr;
    logic          pwrite, psel, penable;
    logic [DW-1:0] pwdata;
    logic          pstrb;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0, pslverr = 1'b0;

    int n_chk = 0, n_pass = 0, cyc = 0;

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: what a transfer should look like, given how long the slave stalls.
    function automatic void model(input bit wr, input int waits, input bit err,
                                  input logic [DW-1:0] rd, output int acc,
                                  output logic [DW-1:0] erd, output bit eerr, output bit eto);
        if (waits >= TO) begin
            acc = TO; erd = '0; eerr = 1'b1; eto = 1'b1;
        end else begin
            acc = waits + 1; erd = wr ? '0 : rd; eerr = err; eto = 1'b0;
        end
    endfunction

    // This task is called at a negedge. The slave holds pready low for `waits` ACCESS
    // cycles, then answers with rd/err. The response is held off for `hold` cycles.
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input bit sb, input int waits, input bit err, input logic [DW-1:0] rd,
                        input int hold, input bit keep, output int t_acc);
        int g, acc, eacc, lat;
        logic [DW-1:0] erd;
        bit eerr, eto;
        logic [31:0] bus_exp, rsp_snap;
        model(wr, waits, err, rd, eacc, erd, eerr, eto);
        bus_exp = {a, wd, (wr ? sb : 1'b0), wr};
        if (hold > 0) rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_strb = sb;
        g = 0;
        while (!cmd_ready && g < 20) begin @(negedge pclk); g++; end
        t_acc = cyc;
        chk("accept_bound", 32'(g < 20), 32'd1);
        if (g >= 20) begin cmd_valid = 1'b0; return; end
        @(negedge pclk);
        cmd_valid = 1'b0; cmd_wdata = 8'($urandom); cmd_addr = 4'($urandom);
        chk("setup_psel_pen", {psel, penable}, 2'b10);
        chk("setup_bus", {paddr, pwdata, pstrb, pwrite}, bus_exp);
        pready = 1'($urandom); pslverr = 1'($urandom);
        acc = 0;
        while (acc < 40) begin
            @(negedge pclk);
            if (!(psel && penable)) break;
            acc++;
            chk("access_bus", {paddr, pwdata, pstrb, pwrite}, bus_exp);
            pready  = (acc - 1 == waits);
            pslverr = pready ? err : 1'($urandom);
            prdata  = pready ? rd : 8'($urandom);
        end
        pready = 1'b0; pslverr = 1'b0; prdata = 8'($urandom);
        lat = cyc - t_acc;
        chk("access_cycles", acc, eacc);
        chk("rsp_latency", lat, 2 + eacc);
        chk("rsp_valid_bus_idle", {rsp_valid, psel, penable, cmd_ready}, 4'b1000);
        chk("rsp_fields", {rsp_rdata, rsp_err, rsp_timeout}, {erd, eerr, eto});
        rsp_snap = {rsp_rdata, rsp_err, rsp_timeout};
        for (int i = 0; i < hold; i++) begin
            @(negedge pclk);
            chk("hold_valid_noready", {rsp_valid, cmd_ready, psel}, 3'b100);
            chk("hold_stable", {rsp_rdata, rsp_err, rsp_timeout}, rsp_snap);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        chk("rsp_done", {rsp_valid, cmd_ready}, 2'b01);
        if (!keep) rsp_ready = 1'b0;
    endtask

    initial begin
        int t, t_prev;
        bit wr, er;
        int w, h;
        logic [DW-1:0] d, r;
        logic [AW-1:0] a;

        // Reset state
        #1;
        chk("reset_outputs", {cmd_ready, rsp_valid, psel, penable, paddr, pwdata, pstrb},
            '0);
        @(negedge pclk); @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);
        chk("cmd_ready_after_reset", cmd_ready, 1'b1);

        // Reset while in ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd1;
        @(negedge pclk); cmd_valid = 1'b0; pready = 1'b0;
        @(negedge pclk);
        chk("pre_reset_access", {psel, penable}, 2'b11);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_mid_access", {psel, penable, cmd_ready, rsp_valid}, 4'b0000);
        @(negedge pclk); rst_n = 1'b1;
        @(negedge pclk);
        chk("cmd_ready_after_rerelease", {cmd_ready, psel}, 2'b10);

        // Directed transfers
        xfer(1, 4'd2, 8'h05, 1'b1, 0, 0, 8'h77, 0, 0, t);      // zero-wait write
        xfer(0, 4'd3, 8'h5A, 1'b1, 3, 0, 8'h0A, 0, 0, t);      // wait-state read
        xfer(1, 4'd4, 8'h33, 1'b1, 0, 1, 8'h00, 0, 0, t);      // slave error
        xfer(0, 4'd6, 8'h00, 1'b0, 99, 0, 8'hFF, 0, 0, t);     // timeout
        xfer(0, 4'd7, 8'h00, 1'b0, 3, 1, 8'hC3, 1, 0, t);      // last edge before timeout

        // Backpressure, then back-to-back traffic with rsp_ready held high
        xfer(1, 4'd8, 8'h11, 1'b1, 0, 0, 8'h00, 5, 1, t);
        xfer(0, 4'd9, 8'h00, 1'b0, 0, 0, 8'h22, 0, 1, t_prev);
        xfer(1, 4'hA, 8'h33, 1'b0, 0, 0, 8'h00, 0, 1, t);
        chk("b2b_spacing_3", t - t_prev, 4);
        t_prev = t;
        xfer(0, 4'hB, 8'h00, 1'b0, 0, 1, 8'h44, 0, 1, t);
        chk("b2b_spacing_4", t - t_prev, 4);
        rsp_ready = 1'b0;

        // Randomized traffic checked against the model
        for (int k = 0; k < 24; k++) begin
            wr = 1'($urandom); er = 1'($urandom);
            a = 4'($urandom); d = 8'($urandom); r = 8'($urandom);
            w = $urandom_range(0, 5); h = $urandom_range(0, 3);
            xfer(wr, a, d, 1'($urandom), w, er, r, h, 0, t);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
Synthesisable, parametrised APB4 master driven by a valid/ready command port and returning results on a valid/ready response port. It replaces the task-based bench master, so both RTL hosts and benches issue APB transfers through the same handshake. Adds byte strobes, PSLVERR capture and a wait-state timeout. Sits between a host or sequencer and one APB slave segment, with PSEL already decoded.

Parameters:
ADDR_W, 4, width of paddr and cmd_addr.
DATA_W, 8, width of pwdata/prdata; must be a multiple of 8.
TIMEOUT, 16, maximum consecutive ACCESS cycles with pready low before abort; 0 disables the timeout. Counter width is clog2(TIMEOUT+1).

Ports:
pclk  in  1  APB clock; every flop uses the rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  host presents a command.
cmd_ready  out  1  master accepts a command this cycle.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_W  transfer address.
cmd_wdata  in  DATA_W  write data.
cmd_strb  in  DATA_W/8  write byte strobes.
rsp_valid  out  1  response is available.
rsp_ready  in  1  host consumes the response.
rsp_rdata  out  DATA_W  read data; 0 for writes and on timeout.
rsp_err  out  1  pslverr was sampled, or the transfer timed out.
rsp_timeout  out  1  the transfer was aborted by the timeout.
paddr  out  ADDR_W  APB address.
pwrite  out  1  APB direction.
psel  out  1  APB select.
penable  out  1  APB enable.
pwdata  out  DATA_W  APB write data.
pstrb  out  DATA_W/8  APB strobes; forced to 0 on reads.
prdata  in  DATA_W  APB read data.
pready  in  1  APB ready.
pslverr  in  1  APB slave error.

Behaviour:
- Reset (asynchronous, rst_n low): all outputs go to 0 immediately, state goes to IDLE, timeout counter clears. This holds mid-transfer; there is no recovery of a transfer that was in flight.
- FSM states and transitions:
  - IDLE: cmd_ready=1. A command is accepted when cmd_valid && cmd_ready. On acceptance, the command is registered onto paddr/pwrite/pwdata/pstrb and the FSM moves to SETUP.
  - SETUP: psel=1, penable=0. Exactly one cycle, then ACCESS.
  - ACCESS: psel=1, penable=1. On an edge that samples pready=1: capture prdata (reads only) and pslverr, drop psel and penable, go to RESP.
  - Timeout: if TIMEOUT>0 and pready has been low on TIMEOUT consecutive ACCESS edges, the transfer aborts at that edge. psel and penable drop, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - RESP: rsp_valid=1; the response is held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE and clear rsp_valid.
- cmd_ready is 0 in every state except IDLE. There is one outstanding transfer at most, and commands are never dropped.
- paddr, pwrite, pwdata and pstrb stay stable from SETUP until the transfer completes, and keep their last values in IDLE.
- Minimum latency: a command accepted at edge N puts SETUP on the bus in cycle N+1 and ACCESS in N+2. With zero wait states, rsp_valid rises in cycle N+3.
- Back-to-back throughput with rsp_ready tied high is one transfer every 4 cycles.
- rsp_err = pslverr sampled on the completing edge, OR the timeout.
- pslverr is ignored in every state except ACCESS with pready=1.
- For writes, rsp_rdata = 0.
- The timeout counter clears on entry to SETUP and counts only ACCESS edges where pready is low.
- TIMEOUT=1: a slave that is not ready on the first ACCESS edge times out immediately.
- If rsp_ready is already high when rsp_valid rises, the response completes in one cycle.

Test Plan:
- Reset mid-ACCESS: assert rst_n=0 while psel=1 and penable=1 → psel, penable, cmd_ready and rsp_valid are all 0 before the next edge. After release, cmd_ready=1.
- Zero-wait write: addr 2, data 5, strb 1, pready tied 1 → one SETUP cycle then one ACCESS cycle. paddr=2 and pwdata=5 are stable throughout. Response is rsp_err=0, rsp_rdata=0, with rsp_valid 3 cycles after acceptance.
- Wait-state read: addr 3, slave holds pready low for 3 ACCESS cycles, then returns 0x0A → penable is high for 4 cycles. Response is rsp_rdata=0x0A, rsp_err=0, and pstrb=0 during the transfer.
- Slave error: write to addr 4 with pslverr=1 on the completing edge → rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT=4, pready held at 0 → the transfer aborts after 4 ACCESS edges. Response is rsp_err=1, rsp_timeout=1, rsp_rdata=0, and the bus returns to idle.
- Backpressure and back-to-back: 4 commands queued, rsp_ready low for 5 cycles on the first → cmd_ready stays 0 while that response is pending and the response is held stable. All 4 transfers then complete in order; with rsp_ready high they run at 4-cycle spacing.
